// File: rtl/two_to_four_dec.sv
// Registered 2-to-4 one-hot decoder with selectable output polarity.
// Reset asserts asynchronously; release passes through a 2-flop synchronizer.
module two_to_four_dec #(
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] A,
   output logic       W,
   output logic       X,
   output logic       Y,
   output logic       Z
);

   logic [1:0] sync_q;
   logic [3:0] dec_q;
   logic [3:0] out_q;

   // Any select that is not a clean 00..11 (X/Z in simulation) yields no active line.
   function automatic logic [3:0] decode(input logic [1:0] sel);
      case (sel)
         2'b00:   decode = 4'b0001;
         2'b01:   decode = 4'b0010;
         2'b10:   decode = 4'b0100;
         2'b11:   decode = 4'b1000;
         default: decode = 4'b0000;
      endcase
   endfunction

   // Reset release synchronizer: sync_q[0] arms loading on the 2nd edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   // Decode register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q <= 4'b0000;
      end else if (sync_q[0]) begin
         dec_q <= decode(A);
      end
   end

   // sync_q[1] rises on the same edge as the first load, so the mask only
   // guarantees the outputs stay inactive until the synchronizer has settled.
   assign out_q = (dec_q & {4{sync_q[1]}}) ^ {4{OUT_ACTIVE_LOW}};

   assign W = out_q[0];
   assign X = out_q[1];
   assign Y = out_q[2];
   assign Z = out_q[3];

endmodule

// File: tb/tb_two_to_four_dec.sv
// Scoreboard bench for two_to_four_dec: both output polarities driven from
// one stimulus stream, expected one-hot codes queued by a reference model.
module tb_two_to_four_dec;

   logic       clk;
   logic       rst_n;
   logic [1:0] A;
   logic       w0, x0, y0, z0;
   logic       w1, x1, y1, z1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] exp_q[$];
   int         run_edges = 0;

   two_to_four_dec #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .rst_n(rst_n), .A(A), .W(w0), .X(x0), .Y(y0), .Z(z0)
   );

   two_to_four_dec #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk), .rst_n(rst_n), .A(A), .W(w1), .X(x1), .Y(y1), .Z(z1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req)
         $display("FAIL %s: got ZYXW=%b, required ZYXW=%b at %0t", name, act, req, $time);
      else
         n_pass++;
   endtask

   // Reference: selected line = 1 << code; nothing while in reset, for the
   // first edge after release, or when the code is unknown.
   function automatic logic [3:0] model(input logic [1:0] sel, input int edges);
      if (edges < 2 || $isunknown(sel)) return 4'b0000;
      return 4'b0001 << sel;
   endfunction

   // Drive one cycle's inputs on the falling edge and queue the response
   // expected just after the following rising edge.
   task automatic step(input logic rst_val, input logic [1:0] a_val);
      @(negedge clk);
      rst_n = rst_val;
      A     = a_val;
      if (!rst_n) run_edges = 0;
      else if (run_edges < 2) run_edges++;
      exp_q.push_back(rst_n ? model(A, run_edges) : 4'b0000);
   endtask

   task automatic drop_reset_between_edges(input string name);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      run_edges = 0;
      #1;
      check({name, "_hi"}, {z0, y0, x0, w0}, 4'b0000);
      check({name, "_lo"}, {z1, y1, x1, w1}, 4'b1111);
   endtask

   // Monitor: one response per rising edge, compared against the queue head
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_underflow: got no queued expectation, required one at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("decode_hi", {z0, y0, x0, w0}, e);
            check("decode_lo", {z1, y1, x1, w1}, ~e);
         end
      end
   end

   initial begin
      logic [1:0] a_unk;
      rst_n = 1'b0;
      A     = 2'b00;
      exp_q.push_back(4'b0000);
      #1;
      check("reset_hi", {z0, y0, x0, w0}, 4'b0000);
      check("reset_lo", {z1, y1, x1, w1}, 4'b1111);

      // Held reset, then release: W appears on the 2nd edge after release
      step(1'b0, 2'd0);
      step(1'b0, 2'd0);
      step(1'b1, 2'd0);
      step(1'b1, 2'd0);
      step(1'b1, 2'd0);

      // Sweep, each code held for two cycles
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 2'(c));
         step(1'b1, 2'(c));
      end

      // Back-to-back wrap-around Z <-> W
      for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 2'd3 : 2'd0);

      // Asynchronous reset between edges while Y is active
      step(1'b1, 2'd2);
      step(1'b1, 2'd2);
      drop_reset_between_edges("async_mid");
      step(1'b0, 2'd2);
      step(1'b1, 2'd2);
      step(1'b1, 2'd2);
      step(1'b1, 2'd2);

      // Polarity sample with A=1
      step(1'b1, 2'd1);
      step(1'b1, 2'd1);

      // Unknown select code
      a_unk = 2'bx1;
      step(1'b1, a_unk);
      step(1'b1, 2'd3);

      // Randomized traffic with occasional resets and unknown codes
      for (int i = 0; i < 300; i++) begin
         logic r;
         logic [1:0] a;
         r = ($urandom_range(0, 24) != 0);
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) a = a_unk;
         if ($urandom_range(0, 59) == 0) drop_reset_between_edges("async_rand");
         step(r, a);
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
